// File: rtl/fc_pkg.sv
// Shared types and defaults for the fc_84 layer sequencer.
package fc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam int DEF_OUT_WIDTH = 16;
   localparam int DEF_ADDR_W    = 8;
   localparam int FC84_LAT      = 10;

endpackage

// File: rtl/fc_argmax_trk.sv
// Running signed maximum with its index; strict compare so ties keep the lower index.
module fc_argmax_trk
   import fc_pkg::*;
#(
   parameter int W  = DEF_OUT_WIDTH,
   parameter int AW = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                upd,
   input  logic [AW-1:0]       idx,
   input  logic signed [W-1:0] val,
   output logic [AW-1:0]       best_idx,
   output logic signed [W-1:0] best_val
);

   localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_idx <= '0;
         best_val <= '0;
      end else if (clr) begin
         best_idx <= '0;
         best_val <= MOST_NEG;
      end else if (upd && (val > best_val)) begin
         best_idx <= idx;
         best_val <= val;
      end
   end

endmodule

// File: rtl/fc_layer_seq.sv
// Issues one neuron row per cycle to the fc_84 pipeline, collects its results
// into the result buffer and reports the signed argmax at the end of the layer.
module fc_layer_seq
   import fc_pkg::*;
#(
   parameter int N_OUT     = 10,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int PIPE_LAT  = FC84_LAT,
   parameter int TIMEOUT   = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic                        vec_hold,
   output logic                        rom_rd,
   output logic [ADDR_W-1:0]           rom_addr,
   output logic                        fc_valid_in,
   input  logic                        fc_valid_out,
   input  logic signed [OUT_WIDTH-1:0] fc_out,
   output logic                        res_we,
   output logic [ADDR_W-1:0]           res_addr,
   output logic [OUT_WIDTH-1:0]        res_data,
   output logic [ADDR_W-1:0]           class_idx,
   output logic signed [OUT_WIDTH-1:0] class_val
);

   if (N_OUT < 1 || N_OUT > (1 << ADDR_W) || PIPE_LAT < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("fc_layer_seq: illegal parameter combination");
   end

   // One extra bit so ret_cnt can hold N_OUT itself.
   localparam int CW  = ADDR_W + 1;
   localparam int WDW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LAST    = CW'(N_OUT - 1);
   localparam logic [CW-1:0]  FULL    = CW'(N_OUT);
   localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

   state_t                      state;
   logic [CW-1:0]               iss_cnt;
   logic [CW-1:0]               ret_cnt;
   logic [WDW-1:0]              wd_cnt;
   logic [ADDR_W-1:0]           best_idx;
   logic signed [OUT_WIDTH-1:0] best_val;
   logic                        accept;
   logic                        overrun;
   logic                        trk_clr;

   assign accept   = fc_valid_out && busy && (ret_cnt != FULL);
   assign overrun  = fc_valid_out && busy && (ret_cnt == FULL);
   assign trk_clr  = (state == S_IDLE) && start;
   assign vec_hold = busy;

   fc_argmax_trk #(
      .W  (OUT_WIDTH),
      .AW (ADDR_W)
   ) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (trk_clr),
      .upd      (accept),
      .idx      (ret_cnt[ADDR_W-1:0]),
      .val      (fc_out),
      .best_idx (best_idx),
      .best_val (best_val)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         iss_cnt     <= '0;
         ret_cnt     <= '0;
         wd_cnt      <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         rom_rd      <= 1'b0;
         rom_addr    <= '0;
         fc_valid_in <= 1'b0;
         res_we      <= 1'b0;
         res_addr    <= '0;
         res_data    <= '0;
         class_idx   <= '0;
         class_val   <= '0;
      end else begin
         rom_rd      <= 1'b0;
         fc_valid_in <= rom_rd;
         res_we      <= 1'b0;
         done        <= 1'b0;

         if (accept) begin
            res_we   <= 1'b1;
            res_addr <= ret_cnt[ADDR_W-1:0];
            res_data <= fc_out;
            ret_cnt  <= ret_cnt + 1'b1;
         end
         if (overrun) begin
            err <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_ISSUE;
                  iss_cnt <= '0;
                  ret_cnt <= '0;
                  err     <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            S_ISSUE: begin
               rom_rd   <= 1'b1;
               rom_addr <= iss_cnt[ADDR_W-1:0];
               iss_cnt  <= iss_cnt + 1'b1;
               if (iss_cnt == LAST) begin
                  state  <= S_DRAIN;
                  wd_cnt <= '0;
               end
            end
            S_DRAIN: begin
               if (ret_cnt == FULL) begin
                  state     <= S_FIN;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  class_idx <= best_idx;
                  class_val <= best_val;
               end else if (fc_valid_out) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == WD_LAST) begin
                  // Pipeline went quiet: finish with whatever was collected.
                  state     <= S_FIN;
                  err       <= 1'b1;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  class_idx <= best_idx;
                  class_val <= best_val;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq with a behavioural ROM + fixed-latency pipeline model.
module tb_fc_layer_seq;

   localparam int N_OUT = 10;
   localparam int OW    = 16;
   localparam int AW    = 8;
   localparam int LAT   = 10;
   localparam int TMO   = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic start = 1'b0;
   logic clr   = 1'b0;

   logic                 busy, done, err, vec_hold, rom_rd, fc_valid_in, res_we;
   logic [AW-1:0]        rom_addr, res_addr, class_idx;
   logic [OW-1:0]        res_data;
   logic signed [OW-1:0] class_val;
   logic                 fc_valid_out;
   logic signed [OW-1:0] fc_out;

   fc_layer_seq #(
      .N_OUT     (N_OUT),
      .OUT_WIDTH (OW),
      .ADDR_W    (AW),
      .PIPE_LAT  (LAT),
      .TIMEOUT   (TMO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .vec_hold     (vec_hold),
      .rom_rd       (rom_rd),
      .rom_addr     (rom_addr),
      .fc_valid_in  (fc_valid_in),
      .fc_valid_out (fc_valid_out),
      .fc_out       (fc_out),
      .res_we       (res_we),
      .res_addr     (res_addr),
      .res_data     (res_data),
      .class_idx    (class_idx),
      .class_val    (class_val)
   );

   always #5 clk = ~clk;

   int ecnt = 0;
   initial forever begin
      @(posedge clk);
      ecnt = ecnt + 1;
   end

   // ROM returns the neuron result directly; rows at index >= keep are dropped.
   logic signed [OW-1:0] tbl [N_OUT];
   int                   keep = N_OUT;
   logic signed [OW-1:0] rom_q    = '0;
   logic [AW-1:0]        rom_a    = '0;
   logic                 rom_keep = 1'b0;
   logic [LAT-1:0]       vpipe    = '0;
   logic signed [OW-1:0] dpipe [LAT] = '{default: '0};

   assign fc_valid_out = vpipe[LAT-1];
   assign fc_out       = dpipe[LAT-1];

   initial forever begin
      @(posedge clk);
      if (rom_rd) begin
         rom_q    <= tbl[int'(rom_addr) % N_OUT];
         rom_a    <= rom_addr;
         rom_keep <= (int'(rom_addr) < keep);
      end
      vpipe    <= {vpipe[LAT-2:0], fc_valid_in & rom_keep};
      dpipe[0] <= rom_q;
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0]        addr;
      logic signed [OW-1:0] data;
   } exp_t;

   exp_t                 exp_q [$];
   int                   rd_cnt, we_cnt, done_cnt, first_rd, first_we, last_we, done_at;
   logic [AW-1:0]        got_idx;
   logic signed [OW-1:0] got_val;
   logic                 got_err;

   // Monitor: expectations are pushed as rows enter the pipeline, popped on res_we.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (clr) begin
         exp_q.delete();
         rd_cnt = 0; we_cnt = 0; done_cnt = 0;
         first_rd = -1; first_we = -1; last_we = -1; done_at = -1;
      end
      if (fc_valid_in && rom_keep) begin
         e.addr = rom_a;
         e.data = rom_q;
         exp_q.push_back(e);
      end
      if (rom_rd) begin
         if (rd_cnt == 0) first_rd = ecnt;
         rd_cnt++;
      end
      if (res_we) begin
         if (we_cnt == 0) first_we = ecnt;
         last_we = ecnt;
         we_cnt++;
         if (exp_q.size() == 0) begin
            check_val("res_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("res  addr=%0d data=%0d (exp %0d/%0d)", res_addr, $signed(res_data),
                     e.addr, $signed(e.data));
            check_val("res_addr", res_addr, e.addr);
            check_val("res_data", $signed(res_data), $signed(e.data));
         end
      end
      if (done) begin
         done_cnt++;
         done_at = ecnt;
         got_idx = class_idx;
         got_val = class_val;
         got_err = err;
      end
   end

   int t0 = 0;

   task automatic set_tbl(input int v [N_OUT], input int k);
      for (int i = 0; i < N_OUT; i++) tbl[i] = OW'(v[i]);
      keep = k;
   endtask

   task automatic start_job();
      @(negedge clk);
      #1;
      clr   = 1'b1;
      start = 1'b1;
      t0    = ecnt + 1;
      @(negedge clk);
      #1;
      clr   = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      check_val({tag, "_done_seen"}, (done_cnt > 0), 1);
   endtask

   task automatic check_job(input string tag, input int exp_done, input int exp_idx,
                            input int exp_val, input int exp_err, input int exp_we);
      $display("job  %s done@%0d class=%0d val=%0d err=%0d", tag, done_at - t0, got_idx,
               got_val, got_err);
      check_val({tag, "_done_cycle"}, done_at - t0, exp_done);
      check_val({tag, "_class_idx"}, got_idx, exp_idx);
      check_val({tag, "_class_val"}, got_val, exp_val);
      check_val({tag, "_err"}, got_err, exp_err);
      check_val({tag, "_first_rd"}, first_rd - t0, 1);
      check_val({tag, "_rd_cnt"}, rd_cnt, N_OUT);
      check_val({tag, "_first_we"}, first_we - t0, 13);
      check_val({tag, "_we_cnt"}, we_cnt, exp_we);
      check_val({tag, "_sb_left"}, exp_q.size(), 0);
   endtask

   function automatic longint outs();
      return longint'({busy, done, err, vec_hold, rom_rd, fc_valid_in, res_we,
                       rom_addr, res_addr, class_idx, res_data, class_val});
   endfunction

   int nom  [N_OUT] = '{5, -3, 9, 9, 0, 1, 2, -8, 7, 4};
   int neg  [N_OUT] = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
   int drp  [N_OUT] = '{1, 2, 3, 4, 5, 6, 100, 100, 100, 100};
   int b2b  [N_OUT] = '{3, 7, -2, 7, 1, 0, 0, 0, 0, 0};

   initial begin
      #3 rst_n = 1'b0;
      #1 check_val("reset_outputs", outs(), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      set_tbl(nom, N_OUT);
      start_job();
      wait_done("nominal");
      check_job("nominal", 23, 2, 9, 0, N_OUT);

      // start in the done cycle lands in FIN and must not launch a job
      start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      #2;
      check_val("fin_start_rd_cnt", rd_cnt, N_OUT);
      check_val("fin_start_busy", busy, 0);

      set_tbl(neg, N_OUT);
      start_job();
      wait_done("allneg");
      check_job("allneg", 23, 9, -91, 0, N_OUT);

      set_tbl(nom, N_OUT);
      start_job();
      repeat (3) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      wait_done("dblstart");
      check_job("dblstart", 23, 2, 9, 0, N_OUT);
      repeat (30) @(negedge clk);
      #2;
      check_val("dblstart_rd_total", rd_cnt, N_OUT);
      check_val("dblstart_done_total", done_cnt, 1);

      set_tbl(drp, 6);
      start_job();
      wait_done("drop");
      check_job("drop", 18 + TMO, 5, 6, 1, 6);
      check_val("drop_done_after_last", done_at - last_we, TMO);

      // next job starts in the first IDLE cycle after done
      set_tbl(b2b, N_OUT);
      start_job();
      wait_done("b2b");
      check_job("b2b", 23, 1, 7, 0, N_OUT);

      set_tbl(nom, N_OUT);
      start_job();
      repeat (15) @(negedge clk);
      #1 rst_n = 1'b0;
      clr = 1'b1;
      #1 check_val("midjob_reset_outputs", outs(), 0);
      @(negedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #2;
      check_val("post_reset_we_cnt", we_cnt, 0);
      check_val("post_reset_done_cnt", done_cnt, 0);

      start_job();
      wait_done("after_reset");
      check_job("after_reset", 23, 2, 9, 0, N_OUT);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "simulation time limit");
   end

endmodule
